// File: rtl/jtdd2_arb_pkg.sv
// Shared definitions for the JTDD2 SDRAM read arbiter: slot count, cache tag width,
// FSM encoding and the round-robin pick among the three secondary slots.
package jtdd2_arb_pkg;

  localparam int SLOTS = 4;
  localparam int TAG_W = 21;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DATA = 2'd2
  } arb_state_t;

  // Walks 1->2->3->1 starting just after the last granted slot; bit 0 of req is ignored
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] cand;
    logic       found;
    rr_pick = last;
    cand    = last;
    found   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cand = (cand == 2'd3) ? 2'd1 : cand + 2'd1;
      if (!found && req[cand]) begin
        rr_pick = cand;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/jtdd2_sdram_arb_if.sv
// Bundle of requester slots plus the SDRAM controller read channel.
// master = surrounding system (CPUs and controller), slave = the arbiter.
interface jtdd2_sdram_arb_if;

  logic        downloading;
  logic        slot0_cs,   slot1_cs,   slot2_cs,   slot3_cs;
  logic [21:0] slot0_addr, slot1_addr, slot2_addr, slot3_addr;
  logic        slot0_ok,   slot1_ok,   slot2_ok,   slot3_ok;
  logic [15:0] slot0_dout, slot1_dout, slot2_dout, slot3_dout;
  logic        sdram_req;
  logic [21:0] sdram_addr;
  logic        sdram_ack;
  logic        data_rdy;
  logic [31:0] data_read;
  logic        refresh_en;

  modport master (
    output downloading,
    output slot0_cs, slot1_cs, slot2_cs, slot3_cs,
    output slot0_addr, slot1_addr, slot2_addr, slot3_addr,
    input  slot0_ok, slot1_ok, slot2_ok, slot3_ok,
    input  slot0_dout, slot1_dout, slot2_dout, slot3_dout,
    input  sdram_req, sdram_addr, refresh_en,
    output sdram_ack, data_rdy, data_read
  );

  modport slave (
    input  downloading,
    input  slot0_cs, slot1_cs, slot2_cs, slot3_cs,
    input  slot0_addr, slot1_addr, slot2_addr, slot3_addr,
    output slot0_ok, slot1_ok, slot2_ok, slot3_ok,
    output slot0_dout, slot1_dout, slot2_dout, slot3_dout,
    output sdram_req, sdram_addr, refresh_en,
    input  sdram_ack, data_rdy, data_read
  );

endinterface

// File: rtl/jtdd2_arb_line.sv
// One-line read cache owned by a single requester: 32-bit line holding an even/odd word pair.
module jtdd2_arb_line
  import jtdd2_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             we,
  input  logic [TAG_W-1:0] wtag,
  input  logic [31:0]      wdata,
  input  logic             cs,
  input  logic [21:0]      addr,
  output logic             hit,
  output logic             miss,
  output logic [15:0]      dout
);

  logic             valid;
  logic [TAG_W-1:0] tag;
  logic [31:0]      data;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      valid <= 1'b0;
    end else if (we) begin
      valid <= 1'b1;
      tag   <= wtag;
      data  <= wdata;
    end
  end

  // A download invalidates the line at once, not only from the next cycle on
  assign hit  = cs && valid && !clr && (tag == addr[21:1]);
  assign miss = cs && !hit;
  assign dout = addr[0] ? data[31:16] : data[15:0];

endmodule

// File: rtl/jtdd2_sdram_arb.sv
// Four-slot SDRAM read arbiter: slot 0 (main CPU) has absolute priority,
// slots 1..3 share the controller round-robin; one request outstanding at a time.
module jtdd2_sdram_arb
  import jtdd2_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  jtdd2_sdram_arb_if.slave  bus
);

  arb_state_t       state, next_state;
  logic [1:0]       gnt, next_gnt, rr_last, next_rr, pick;
  logic             req, next_req;
  logic [21:0]      req_addr, next_addr;
  logic [SLOTS-1:0] cs, hit, miss, we;
  logic [21:0]      addr [SLOTS];
  logic [15:0]      dout [SLOTS];

  assign cs      = {bus.slot3_cs, bus.slot2_cs, bus.slot1_cs, bus.slot0_cs};
  assign addr[0] = bus.slot0_addr;
  assign addr[1] = bus.slot1_addr;
  assign addr[2] = bus.slot2_addr;
  assign addr[3] = bus.slot3_addr;

  assign bus.slot0_ok   = hit[0];
  assign bus.slot1_ok   = hit[1];
  assign bus.slot2_ok   = hit[2];
  assign bus.slot3_ok   = hit[3];
  assign bus.slot0_dout = dout[0];
  assign bus.slot1_dout = dout[1];
  assign bus.slot2_dout = dout[2];
  assign bus.slot3_dout = dout[3];

  for (genvar i = 0; i < SLOTS; i++) begin : g_line
    jtdd2_arb_line u_line (
      .clk   (clk),
      .rst   (rst),
      .clr   (bus.downloading),
      .we    (we[i]),
      .wtag  (req_addr[21:1]),
      .wdata (bus.data_read),
      .cs    (cs[i]),
      .addr  (addr[i]),
      .hit   (hit[i]),
      .miss  (miss[i]),
      .dout  (dout[i])
    );
  end

  assign pick = miss[0] ? 2'd0 : rr_pick({miss[3:1], 1'b0}, rr_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= 2'd0;
      rr_last  <= 2'd3;
      req      <= 1'b0;
      req_addr <= '0;
    end else begin
      state    <= next_state;
      gnt      <= next_gnt;
      rr_last  <= next_rr;
      req      <= next_req;
      req_addr <= next_addr;
    end
  end

  // The line is written on the WAIT_DATA exit, so a new grant can only start one cycle later
  always_comb begin
    next_state = state;
    next_gnt   = gnt;
    next_rr    = rr_last;
    next_req   = req;
    next_addr  = req_addr;
    we         = '0;
    case (state)
      IDLE: begin
        if (|miss) begin
          next_state = WAIT_ACK;
          next_gnt   = pick;
          next_addr  = {addr[pick][21:1], 1'b0};
          next_req   = 1'b1;
          if (pick != 2'd0) next_rr = pick;
        end
      end
      WAIT_ACK: begin
        if (bus.sdram_ack) begin
          next_req   = 1'b0;
          next_state = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (bus.data_rdy) begin
          we[gnt]    = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    if (bus.downloading) begin
      next_state = IDLE;
      next_gnt   = gnt;
      next_rr    = rr_last;
      next_req   = 1'b0;
      next_addr  = req_addr;
      we         = '0;
    end
  end

  assign bus.sdram_req  = req;
  assign bus.sdram_addr = req_addr;
  assign bus.refresh_en = !rst && !bus.downloading && (state == IDLE) && !(|miss);

endmodule

// File: tb/tb_jtdd2_sdram_arb.sv
// Self-checking bench for jtdd2_sdram_arb: a behavioural SDRAM controller pops the
// expected request address queue as each request appears and serves a known data pattern.
module tb_jtdd2_sdram_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  cs_tb = 4'b0;
  logic [21:0] addr_tb [4];
  logic [3:0]  ok_v;
  logic [15:0] dout_v [4];

  int          errors = 0;
  int          checks = 0;
  logic [21:0] exp_req [$];
  int          nreq = 0;
  int          nfill = 0;
  int          cst = 0;
  int          cnt = 0;
  int          data_delay = 0;
  bit          ctl_en = 1'b1;
  bit          in_wait_data = 1'b0;
  logic [21:0] paddr;

  jtdd2_sdram_arb_if bus();

  jtdd2_sdram_arb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.slot0_cs   = cs_tb[0];
  assign bus.slot1_cs   = cs_tb[1];
  assign bus.slot2_cs   = cs_tb[2];
  assign bus.slot3_cs   = cs_tb[3];
  assign bus.slot0_addr = addr_tb[0];
  assign bus.slot1_addr = addr_tb[1];
  assign bus.slot2_addr = addr_tb[2];
  assign bus.slot3_addr = addr_tb[3];
  assign ok_v      = {bus.slot3_ok, bus.slot2_ok, bus.slot1_ok, bus.slot0_ok};
  assign dout_v[0] = bus.slot0_dout;
  assign dout_v[1] = bus.slot1_dout;
  assign dout_v[2] = bus.slot2_dout;
  assign dout_v[3] = bus.slot3_dout;

  // Memory contents as seen by the controller model, one 16-bit word per address
  function automatic logic [15:0] word_of(input logic [21:0] a);
    if (a == 22'h060004) return 16'h5555;
    if (a == 22'h060005) return 16'hAAAA;
    return a[15:0] ^ {a[21:16], a[21:18], 6'h2B};
  endfunction

  function automatic logic [21:0] even_of(input logic [21:0] a);
    return {a[21:1], 1'b0};
  endfunction

  // Controller: ack one cycle after seeing req, data_rdy the cycle after ack (+data_delay)
  initial begin
    logic [21:0] e;
    bus.sdram_ack = 1'b0;
    bus.data_rdy  = 1'b0;
    bus.data_read = '0;
    forever begin
      @(posedge clk); #1;
      if (!ctl_en) begin
        cst = 0;
        continue;
      end
      case (cst)
        0: if (bus.sdram_req === 1'b1) begin
             nreq++;
             paddr = bus.sdram_addr;
             checks++;
             if (exp_req.size() == 0) begin
               errors++;
               $display("[TB] FAIL req_order: unexpected request addr=%h, none expected", paddr);
             end else begin
               e = exp_req.pop_front();
               if (paddr !== e) begin
                 errors++;
                 $display("[TB] FAIL req_order: got addr=%h expected %h", paddr, e);
               end
             end
             cst = 1;
           end
        1: begin
             bus.sdram_ack = 1'b1;
             cst = 2;
           end
        2: begin
             bus.sdram_ack = 1'b0;
             in_wait_data  = 1'b1;
             cnt = data_delay;
             if (cnt == 0) begin
               bus.data_rdy  = 1'b1;
               bus.data_read = {word_of(paddr | 22'd1), word_of(paddr)};
               cst = 4;
             end else begin
               cst = 3;
             end
           end
        3: begin
             cnt--;
             if (cnt == 0) begin
               bus.data_rdy  = 1'b1;
               bus.data_read = {word_of(paddr | 22'd1), word_of(paddr)};
               cst = 4;
             end
           end
        default: begin
             bus.data_rdy = 1'b0;
             in_wait_data = 1'b0;
             nfill++;
             cst = 0;
           end
      endcase
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic do_reset();
    ctl_en = 1'b0;
    bus.sdram_ack = 1'b0;
    bus.data_rdy  = 1'b0;
    in_wait_data  = 1'b0;
    cs_tb = 4'b0;
    rst = 1'b1;
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst = 1'b0;
    exp_req.delete();
    ctl_en = 1'b1;
  endtask

  task automatic wait_req(input int target);
    int t = 0;
    while (nreq < target && t < 200) begin
      @(posedge clk); #2;
      t++;
    end
    checks++;
    if (nreq < target) begin
      errors++;
      $display("[TB] FAIL wait_req: requests=%0d expected %0d", nreq, target);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!(exp_req.size() == 0 && cst == 0 && bus.sdram_req === 1'b0) && t < 300) begin
      @(posedge clk); #2;
      t++;
    end
    checks++;
    if (t >= 300) begin
      errors++;
      $display("[TB] FAIL wait_idle: pending=%0d req=%b, expected 0 pending and req=0",
               exp_req.size(), bus.sdram_req);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    addr_tb[0] = 22'h000100; addr_tb[1] = 22'h000200;
    addr_tb[2] = 22'h000300; addr_tb[3] = 22'h000400;
    cs_tb = 4'b1111;
    @(posedge clk); #2;
    checks++;
    if (bus.refresh_en !== 1'b0) begin errors++; $display("[TB] FAIL rst_refresh: got %b expected 0", bus.refresh_en); end
    checks++;
    if (bus.sdram_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_req: got %b expected 0", bus.sdram_req); end
    checks++;
    if (bus.sdram_addr !== 22'h0) begin errors++; $display("[TB] FAIL rst_addr: got %h expected 0", bus.sdram_addr); end
    checks++;
    if (ok_v !== 4'b0) begin errors++; $display("[TB] FAIL rst_ok: got %b expected 0000", ok_v); end
    cs_tb = 4'b0;
    rst = 1'b0;
    @(posedge clk); #2;
    checks++;
    if (bus.refresh_en !== 1'b1) begin errors++; $display("[TB] FAIL idle_refresh: got %b expected 1", bus.refresh_en); end
  endtask

  task automatic test_hit_latency();
    int n = 0;
    addr_tb[2] = 22'h060004;
    exp_req.push_back(22'h060004);
    cs_tb[2] = 1'b1;
    while (n < 20 && ok_v[2] !== 1'b1) begin
      @(posedge clk); #2;
      n++;
    end
    checks++;
    if (n !== 4) begin errors++; $display("[TB] FAIL latency: got %0d cycles expected 4", n); end
    checks++;
    if (dout_v[2] !== 16'h5555) begin errors++; $display("[TB] FAIL even_word: got %h expected 5555", dout_v[2]); end
    addr_tb[2] = 22'h060005;
    #1;
    checks++;
    if (ok_v[2] !== 1'b1 || dout_v[2] !== 16'hAAAA) begin
      errors++;
      $display("[TB] FAIL odd_word: got ok=%b dout=%h expected ok=1 dout=aaaa", ok_v[2], dout_v[2]);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      checks++;
      if (bus.sdram_req !== 1'b0 || bus.refresh_en !== 1'b1) begin
        errors++;
        $display("[TB] FAIL hit_no_req: got req=%b refresh=%b expected req=0 refresh=1",
                 bus.sdram_req, bus.refresh_en);
      end
    end
    cs_tb[2] = 1'b0;
  endtask

  task automatic test_priority();
    int base;
    do_reset();
    base = nreq;
    addr_tb[0] = 22'h010010; addr_tb[1] = 22'h020020; addr_tb[3] = 22'h030031;
    exp_req.push_back(even_of(addr_tb[0]));
    exp_req.push_back(even_of(addr_tb[1]));
    exp_req.push_back(even_of(addr_tb[3]));
    cs_tb = 4'b1011;
    wait_req(base + 3);
    addr_tb[0] = 22'h012346;
    exp_req.push_back(even_of(addr_tb[0]));
    wait_idle();
    checks++;
    if (ok_v !== 4'b1011) begin errors++; $display("[TB] FAIL prio_ok: got %b expected 1011", ok_v); end
    for (int s = 0; s < 4; s++) begin
      if (s == 2) continue;
      checks++;
      if (dout_v[s] !== word_of(addr_tb[s])) begin
        errors++;
        $display("[TB] FAIL prio_dout%0d: got %h expected %h", s, dout_v[s], word_of(addr_tb[s]));
      end
    end
    cs_tb = 4'b0;
  endtask

  task automatic test_round_robin();
    int s;
    int t;
    do_reset();
    for (int i = 1; i < 4; i++) begin
      addr_tb[i] = {i[1:0], 20'h00100} | 22'(i * 6);
      exp_req.push_back(even_of(addr_tb[i]));
    end
    cs_tb = 4'b1110;
    for (int k = 0; k < 6; k++) begin
      s = 1 + (k % 3);
      t = 0;
      while (ok_v[s] !== 1'b1 && t < 100) begin
        @(posedge clk); #2;
        t++;
      end
      checks++;
      if (ok_v[s] !== 1'b1) begin
        errors++;
        $display("[TB] FAIL rr_fill%0d: slot %0d ok=%b expected 1", k, s, ok_v[s]);
      end else if (dout_v[s] !== word_of(addr_tb[s])) begin
        errors++;
        $display("[TB] FAIL rr_dout%0d: got %h expected %h", k, dout_v[s], word_of(addr_tb[s]));
      end
      if (k < 3) begin
        addr_tb[s] = addr_tb[s] + 22'h000441;
        exp_req.push_back(even_of(addr_tb[s]));
      end else begin
        cs_tb[s] = 1'b0;
      end
    end
    wait_idle();
  endtask

  task automatic test_addr_change();
    int t = 0;
    int f;
    do_reset();
    data_delay = 3;
    addr_tb[1] = 22'h001000;
    exp_req.push_back(22'h001000);
    cs_tb[1] = 1'b1;
    while (!in_wait_data && t < 50) begin
      @(posedge clk); #2;
      t++;
    end
    checks++;
    if (!in_wait_data) begin errors++; $display("[TB] FAIL chg_wait: in_wait_data=0 expected 1"); end
    f = nfill;
    addr_tb[1] = 22'h002000;
    exp_req.push_back(22'h002000);
    data_delay = 0;
    t = 0;
    while (nfill == f && t < 50) begin
      @(posedge clk); #2;
      t++;
    end
    checks++;
    if (ok_v[1] !== 1'b0) begin errors++; $display("[TB] FAIL chg_ok_new: got %b expected 0", ok_v[1]); end
    addr_tb[1] = 22'h001000;
    #1;
    checks++;
    if (ok_v[1] !== 1'b1 || dout_v[1] !== word_of(22'h001000)) begin
      errors++;
      $display("[TB] FAIL chg_old_tag: got ok=%b dout=%h expected ok=1 dout=%h",
               ok_v[1], dout_v[1], word_of(22'h001000));
    end
    addr_tb[1] = 22'h002000;
    wait_idle();
    checks++;
    if (ok_v[1] !== 1'b1 || dout_v[1] !== word_of(22'h002000)) begin
      errors++;
      $display("[TB] FAIL chg_refill: got ok=%b dout=%h expected ok=1 dout=%h",
               ok_v[1], dout_v[1], word_of(22'h002000));
    end
    cs_tb = 4'b0;
  endtask

  task automatic test_reset_midfetch();
    int t = 0;
    do_reset();
    ctl_en = 1'b0;
    addr_tb[3] = 22'h003000;
    cs_tb[3] = 1'b1;
    while (bus.sdram_req !== 1'b1 && t < 20) begin
      @(posedge clk); #2;
      t++;
    end
    checks++;
    if (bus.sdram_req !== 1'b1) begin errors++; $display("[TB] FAIL mid_req: got %b expected 1", bus.sdram_req); end
    bus.sdram_ack = 1'b1;
    @(posedge clk); #2;
    bus.sdram_ack = 1'b0;
    rst = 1'b1;
    cs_tb[3] = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    bus.data_rdy  = 1'b1;
    bus.data_read = 32'hDEADBEEF;
    @(posedge clk); #2;
    bus.data_rdy = 1'b0;
    checks++;
    if (bus.sdram_req !== 1'b0 || bus.refresh_en !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_idle: got req=%b refresh=%b expected req=0 refresh=1",
               bus.sdram_req, bus.refresh_en);
    end
    cs_tb[3] = 1'b1;
    #1;
    checks++;
    if (ok_v[3] !== 1'b0 || bus.refresh_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_no_fill: got ok=%b refresh=%b expected ok=0 refresh=0",
               ok_v[3], bus.refresh_en);
    end
    cs_tb[3] = 1'b0;
    @(posedge clk); #2;
    ctl_en = 1'b1;
  endtask

  task automatic test_download();
    do_reset();
    addr_tb[0] = 22'h100000; addr_tb[1] = 22'h200002;
    addr_tb[2] = 22'h300005; addr_tb[3] = 22'h0ABCD7;
    for (int i = 0; i < 4; i++) exp_req.push_back(even_of(addr_tb[i]));
    cs_tb = 4'b1111;
    wait_idle();
    checks++;
    if (ok_v !== 4'b1111) begin errors++; $display("[TB] FAIL dl_pre_ok: got %b expected 1111", ok_v); end
    bus.downloading = 1'b1;
    #1;
    checks++;
    if (ok_v !== 4'b0000) begin errors++; $display("[TB] FAIL dl_ok: got %b expected 0000", ok_v); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      checks++;
      if (bus.sdram_req !== 1'b0 || bus.refresh_en !== 1'b0 || ok_v !== 4'b0) begin
        errors++;
        $display("[TB] FAIL dl_quiet: got req=%b refresh=%b ok=%b expected 0 0 0000",
                 bus.sdram_req, bus.refresh_en, ok_v);
      end
    end
    for (int i = 0; i < 4; i++) exp_req.push_back(even_of(addr_tb[i]));
    bus.downloading = 1'b0;
    #1;
    checks++;
    if (ok_v !== 4'b0000) begin errors++; $display("[TB] FAIL dl_release_ok: got %b expected 0000", ok_v); end
    wait_idle();
    checks++;
    if (ok_v !== 4'b1111) begin errors++; $display("[TB] FAIL dl_refill_ok: got %b expected 1111", ok_v); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dout_v[i] !== word_of(addr_tb[i])) begin
        errors++;
        $display("[TB] FAIL dl_dout%0d: got %h expected %h", i, dout_v[i], word_of(addr_tb[i]));
      end
    end
    cs_tb = 4'b0;
  endtask

  initial begin
    bus.downloading = 1'b0;
    for (int i = 0; i < 4; i++) addr_tb[i] = '0;
    test_reset();
    test_hit_latency();
    test_priority();
    test_round_robin();
    test_addr_change();
    test_reset_midfetch();
    test_download();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jtdd2_sdram_arb.md
JTDD2_SDRAM_ARB -- requirements
Module: jtdd2_sdram_arb

Interface
REQ-001 SHALL have clk, input, 1, system clock (48 MHz); all logic on its rising edge.
REQ-002 SHALL have rst, input, 1, reset; synchronous, active-high.
REQ-003 SHALL have downloading, input, 1, ROM download in progress.
REQ-004 SHALL have slotN_cs, input, 1 each (N=0..3), read request from requester N; slot 0 = main CPU, slots 1..3 = sound, MCU, graphics.
REQ-005 SHALL have slotN_addr, input, 22 each, 16-bit-word SDRAM address, offset already applied.
REQ-006 SHALL have slotN_ok, output, 1 each, slotN_dout valid for the current slotN_addr.
REQ-007 SHALL have slotN_dout, output, 16 each, requested word.
REQ-008 SHALL have sdram_req, output, 1, read request to SDRAM controller.
REQ-009 SHALL have sdram_addr, output, 22, request address, bit 0 always 0.
REQ-010 SHALL have sdram_ack, input, 1, controller accepted request.
REQ-011 SHALL have data_rdy, input, 1, data_read valid this cycle.
REQ-012 SHALL have data_read, input, 32, two consecutive words; [15:0] = even word, [31:16] = odd word.
REQ-013 SHALL have refresh_en, output, 1, controller may refresh.

Function
REQ-014 Each slot SHALL own one 32-bit line: tag[20:0], valid bit, data.
REQ-015 Hit(N) = slotN_cs AND valid(N) AND tag(N)==slotN_addr[21:1]; slotN_ok SHALL equal hit(N) combinationally.
REQ-016 slotN_dout SHALL be line(N)[15:0] when slotN_addr[0]=0, else line(N)[31:16]; value undefined when ok=0.
REQ-017 Miss(N) = slotN_cs AND NOT hit(N).
REQ-018 FSM states: IDLE, WAIT_ACK, WAIT_DATA.
REQ-019 IDLE: if any miss, latch grant and {slot_addr[21:1],0} into sdram_addr, set sdram_req=1, go WAIT_ACK next cycle; else stay.
REQ-020 Grant: slot 0 SHALL win whenever it misses; otherwise round-robin among 1..3, starting after last granted of 1..3 (pointer resets to 3, so slot 1 first).
REQ-021 WAIT_ACK: on sdram_ack, sdram_req SHALL drop next cycle, go WAIT_DATA; sdram_addr held.
REQ-022 WAIT_DATA: on data_rdy, write data_read to granted line, tag=latched address[21:1], valid=1, go IDLE; ok visible the following cycle.
REQ-023 Miss-to-ok latency with ack and data_rdy each one cycle after prior edge SHALL be 4 cycles.
REQ-024 Address or cs change of granted slot mid-fetch SHALL NOT abort; line filled with latched tag, new miss re-arbitrated from IDLE.
REQ-025 data_rdy or sdram_ack outside their waiting state SHALL be ignored.
REQ-026 A new request SHALL NOT be issued in the cycle a line is written; at most one outstanding request.
REQ-027 refresh_en SHALL be 1 only in IDLE with no miss.
REQ-028 While downloading=1: all valid cleared, FSM forced to IDLE, sdram_req=0, refresh_en=0, no grants.
REQ-029 Falling downloading SHALL leave all lines invalid so first post-download read misses.

Reset
REQ-030 On rst: FSM IDLE, sdram_req=0, sdram_addr=0, all valid=0, RR pointer=3, refresh_en=0 in reset cycle.
REQ-031 Reset mid-fetch SHALL abandon request; late data_rdy SHALL NOT write any line.

Structure
REQ-032 State encoding, slot count (4) and tag width (21) SHALL live in shared package jtdd2_arb_pkg.
REQ-033 Per-slot line (tag, valid, data, hit, word mux) SHALL be sub-module jtdd2_arb_line, instantiated 4 times.

Verification
REQ-034 Slot 2 cs, addr 0x06_0004; ack +1, data_rdy 0xAAAA5555 +1 -> slot2_ok 4 cycles after cs, dout 0x5555; addr 0x06_0005 -> dout 0xAAAA same cycle, no new sdram_req.
REQ-035 Slots 0,1,3 miss together -> grant order 0,1,3; slot 0 re-miss before 3 finishes -> granted next after 3.
REQ-036 Slots 1,2,3 miss continuously with changing addresses -> grants 1,2,3,1,2,3; no slot starved.
REQ-037 Slot 1 addr changes 0x1000->0x2000 in WAIT_DATA -> line tag 0x800 filled, ok=0, second request 0x2000 issued from IDLE.
REQ-038 rst pulse in WAIT_DATA, data_rdy next cycle -> no valid set, sdram_req=0, refresh_en=1 once idle without misses.
REQ-039 downloading high after fills -> all ok=0, no sdram_req; released with same addresses -> fresh fetches for every active slot.
